// File: rtl/addr_map_pkg.sv
// ---------------------------------------------------------------------------
// addr_map_pkg
// Shared definitions for the address-translation front-end that sits in
// front of the cuckoo address map.
//   ADDR_WIDTH    : default address / key / value width
//   addr_bits     : address-sized vector type
//   xlate_state_e : translation FSM states
//   page_key()    : page number of an address (address >> shift)
// ---------------------------------------------------------------------------
package addr_map_pkg;

  localparam int ADDR_WIDTH = 64;

  typedef logic [ADDR_WIDTH-1:0] addr_bits;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOOKUP    = 3'd1,
    S_MISS_REQ  = 3'd2,
    S_MISS_WAIT = 3'd3,
    S_INSERT    = 3'd4,
    S_RESP      = 3'd5
  } xlate_state_e;

  // Page number of an address. Upper bits are zero-filled by the shift.
  function automatic addr_bits page_key(input addr_bits addr, input int unsigned shift);
    return addr >> shift;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk   : clock, rising edge
//   rst   : asynchronous, active-high reset (count -> 0)
//   inc   : increment request for this cycle
//   count : current value
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // NOTE: state is updated with non-blocking assignments so every register
  // in the design samples its inputs from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/addr_xlate_stage.sv
// ---------------------------------------------------------------------------
// addr_xlate_stage
// Blocking translation front-end: accepts one address request at a time,
// looks its page up in the address map, and on a miss fetches the mapping
// from the backing store, inserts it into the map, then responds.
// Keeps saturating hit / miss counters.
//
// Ports
//   clk, rst                        : clock; asynchronous active-high reset
//   req_valid/ready, req_addr/id    : request in (ready only when idle)
//   resp_valid/ready, resp_addr/id/err : translated response out
//   map_get_key, map_get_hit/value  : combinational map lookup
//   map_put_valid/ready/key/value   : map insert handshake
//   miss_valid/ready, miss_key      : fill request to backing store
//   fill_valid/value/err            : fill return (no backpressure)
//   hit_count, miss_count           : saturating statistics
// ---------------------------------------------------------------------------
module addr_xlate_stage #(
  parameter int ADDR_WIDTH = addr_map_pkg::ADDR_WIDTH,
  parameter int PAGE_SHIFT = 12,
  parameter int ID_WIDTH   = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [ID_WIDTH-1:0]   req_id,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [ADDR_WIDTH-1:0] resp_addr,
  output logic [ID_WIDTH-1:0]   resp_id,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] map_get_key,
  input  logic                  map_get_hit,
  input  logic [ADDR_WIDTH-1:0] map_get_value,
  output logic                  map_put_valid,
  input  logic                  map_put_ready,
  output logic [ADDR_WIDTH-1:0] map_put_key,
  output logic [ADDR_WIDTH-1:0] map_put_value,
  output logic                  miss_valid,
  input  logic                  miss_ready,
  output logic [ADDR_WIDTH-1:0] miss_key,
  input  logic                  fill_valid,
  input  logic [ADDR_WIDTH-1:0] fill_value,
  input  logic                  fill_err,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  miss_count
);

  import addr_map_pkg::*;

  xlate_state_e state, state_nxt;

  logic [PAGE_SHIFT-1:0] off_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] key_q;
  logic [ADDR_WIDTH-1:0] value_q;
  logic [ADDR_WIDTH-1:0] resp_addr_q;
  logic                  resp_err_q;

  logic hit_inc;
  logic miss_inc;

  // Translated address: page number moved back up, page offset re-attached.
  // Page bits shifted past ADDR_WIDTH are dropped.
  function automatic logic [ADDR_WIDTH-1:0] join_page(
    input logic [ADDR_WIDTH-1:0] page,
    input logic [PAGE_SHIFT-1:0] off
  );
    return (page << PAGE_SHIFT) | {{(ADDR_WIDTH-PAGE_SHIFT){1'b0}}, off};
  endfunction

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  // NOTE: the reset is in the sensitivity list so it takes effect without
  // a clock edge; an in-flight miss is simply dropped back to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Next state and handshake outputs
  // ---------------------------------------------------------------------
  // NOTE: every output of this block is given a default first so no path
  // leaves a value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt     = state;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    miss_valid    = 1'b0;
    map_put_valid = 1'b0;
    hit_inc       = 1'b0;
    miss_inc      = 1'b0;

    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (map_get_hit) begin
          hit_inc   = 1'b1;
          state_nxt = S_RESP;
        end else begin
          miss_inc  = 1'b1;
          state_nxt = S_MISS_REQ;
        end
      end
      S_MISS_REQ: begin
        miss_valid = 1'b1;
        // A fill arriving alongside miss_ready is not looked at here.
        if (miss_ready) state_nxt = S_MISS_WAIT;
      end
      S_MISS_WAIT: begin
        if (fill_valid) state_nxt = fill_err ? S_RESP : S_INSERT;
      end
      S_INSERT: begin
        map_put_valid = 1'b1;
        if (map_put_ready) state_nxt = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Request / response datapath
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      off_q       <= '0;
      id_q        <= '0;
      key_q       <= '0;
      value_q     <= '0;
      resp_addr_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            off_q       <= req_addr[PAGE_SHIFT-1:0];
            id_q        <= req_id;
            key_q       <= ADDR_WIDTH'(page_key(addr_bits'(req_addr), PAGE_SHIFT));
            resp_addr_q <= '0;
            resp_err_q  <= 1'b0;
          end
        end
        S_LOOKUP: begin
          if (map_get_hit) resp_addr_q <= join_page(map_get_value, off_q);
        end
        S_MISS_WAIT: begin
          if (fill_valid) begin
            if (fill_err) begin
              resp_addr_q <= '0;
              resp_err_q  <= 1'b1;
            end else begin
              value_q <= fill_value;
            end
          end
        end
        S_INSERT: begin
          resp_addr_q <= join_page(value_q, off_q);
        end
        default: ;
      endcase
    end
  end

  // Key and value are registers, so they stay stable for every handshake
  // that holds them.
  assign map_get_key   = key_q;
  assign map_put_key   = key_q;
  assign map_put_value = value_q;
  assign miss_key      = key_q;
  assign resp_addr     = resp_addr_q;
  assign resp_id       = id_q;
  assign resp_err      = resp_err_q;

  // ---------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------
  sat_counter #(.W(CNT_WIDTH)) u_hit_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit_inc),
    .count (hit_count)
  );

  sat_counter #(.W(CNT_WIDTH)) u_miss_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (miss_inc),
    .count (miss_count)
  );

endmodule
